// File: rtl/spi_flash_reader.sv
// spi_flash_reader
//   Read-only bus slave for the external SPI NOR flash window. Each word read
//   in the window becomes one SPI READ (0x03) frame: 8 command bits, 24 address
//   bits, 32 data bits. SPI mode 0, MSB first on the wire. The four received
//   bytes are packed little-endian into the returned word.
//
//   Optional feature macro: SPI_FLASH_SEQ_READ_EN
//     When defined, chip select stays low after a read (HOLD). A following read
//     of the next word skips the command and address phases. Any other access
//     closes the burst first.
//
// Ports
//   clk_i, rst_i        system clock, synchronous active-high reset
//   req_i, gnt_o        bus request / one-cycle grant pulse
//   addr_i, we_i        byte address (bits [1:0] ignored), write enable (illegal)
//   be_i, wdata_i       ignored (read-only slave)
//   rvalid_o, rdata_o   one-cycle response pulse and response word (held after)
//   err_o               flags an illegal access together with rvalid_o
//   busy_o              high whenever the FSM is not idle
//   spi_sck_o, spi_cs_no, spi_mosi_o, spi_miso_i   SPI master pins
module spi_flash_reader #(
  parameter logic [31:0] FLASH_BASE_ADDR  = 32'h2000_0000,
  parameter int          FLASH_ADDR_WIDTH = 24,
  parameter int          CLK_DIV          = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        spi_sck_o,
  output logic        spi_cs_no,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  localparam int               DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [32:0]      WINDOW_SIZE = 33'(64'd1 << FLASH_ADDR_WIDTH);
  localparam logic [7:0]       CMD_READ    = 8'h03;
  localparam logic [31:0]      ERR_WORD    = 32'hDEAD_BEEF;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    CMD   = 4'd1,
    ADDR  = 4'd2,
    DATA  = 4'd3,
    RESP  = 4'd4,
    CSGAP = 4'd5,
    ERR   = 4'd6,
    HOLD  = 4'd7
  } state_e;

  // First received byte sits in the top of the shift register; it belongs in rdata[7:0].
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  state_e           state_r;
  logic             gnt_r;
  logic             rvalid_r;
  logic             err_r;
  logic             busy_r;
  logic [31:0]      rdata_r;
  logic             sck_r;
  logic             cs_n_r;
  logic             mosi_r;
  logic [31:0]      tx_r;     // outgoing bits still to be sent, next one at [31]
  logic [31:0]      rx_r;     // incoming data bits
  logic [5:0]       bit_r;    // frame bit 0..63
  logic [DIV_W-1:0] div_r;    // clk_i cycles within the current SCK half
  logic             phase_r;  // 0: SCK low half, 1: SCK high half

  logic [31:0]      offset_s;
  logic [23:0]      flash_addr_s;
  logic [31:0]      frame_s;
  logic             illegal_s;
  logic             unused_s;

  assign offset_s     = addr_i - FLASH_BASE_ADDR;
  assign flash_addr_s = {offset_s[23:2], 2'b00};
  assign frame_s      = {CMD_READ, flash_addr_s};
  assign illegal_s    = we_i | ({1'b0, offset_s} >= WINDOW_SIZE);
  assign unused_s     = ^{be_i, wdata_i, offset_s[1:0]};

`ifdef SPI_FLASH_SEQ_READ_EN
  logic [23:0] last_addr_r;
  logic        seq_hit_s;
  // The last word of the flash never matches: last+4 lies outside the window, so a wrap ends the burst.
  assign seq_hit_s = ~illegal_s & ({offset_s[31:2], 2'b00} == ({8'h00, last_addr_r} + 32'd4));
`endif

  // Single FSM: bus handshake, SPI framing and every registered output
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= IDLE;
      gnt_r    <= 1'b0;
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
      rdata_r  <= 32'h0000_0000;
      sck_r    <= 1'b0;
      cs_n_r   <= 1'b1;
      mosi_r   <= 1'b0;
      tx_r     <= 32'h0000_0000;
      rx_r     <= 32'h0000_0000;
      bit_r    <= 6'd0;
      div_r    <= {DIV_W{1'b0}};
      phase_r  <= 1'b0;
`ifdef SPI_FLASH_SEQ_READ_EN
      last_addr_r <= 24'h00_0000;
`endif
    end else begin
      gnt_r    <= 1'b0;
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_i) begin
            gnt_r  <= 1'b1;
            busy_r <= 1'b1;
            if (illegal_s) begin
              state_r <= ERR;
            end else begin
              state_r <= CMD;
              cs_n_r  <= 1'b0;
              mosi_r  <= frame_s[31];
              tx_r    <= {frame_s[30:0], 1'b0};
              bit_r   <= 6'd0;
              div_r   <= {DIV_W{1'b0}};
              phase_r <= 1'b0;
`ifdef SPI_FLASH_SEQ_READ_EN
              last_addr_r <= flash_addr_s;
`endif
            end
          end
        end
        ERR: begin
          rvalid_r <= 1'b1;
          err_r    <= 1'b1;
          rdata_r  <= ERR_WORD;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
        CMD, ADDR, DATA: begin
          if (div_r != DIV_LAST) begin
            div_r <= div_r + DIV_W'(1);
          end else begin
            div_r <= {DIV_W{1'b0}};
            if (!phase_r) begin
              // Rising SCK edge: the flash has had a full low half to settle MISO.
              phase_r <= 1'b1;
              sck_r   <= 1'b1;
              if (state_r == DATA) begin
                rx_r <= {rx_r[30:0], spi_miso_i};
              end
            end else begin
              phase_r <= 1'b0;
              sck_r   <= 1'b0;
              if (bit_r == 6'd63) begin
                rvalid_r <= 1'b1;
                rdata_r  <= byte_swap(rx_r);
                mosi_r   <= 1'b0;
`ifdef SPI_FLASH_SEQ_READ_EN
                state_r  <= HOLD;
`else
                cs_n_r   <= 1'b1;
                state_r  <= RESP;
`endif
              end else begin
                bit_r  <= bit_r + 6'd1;
                mosi_r <= tx_r[31];
                tx_r   <= {tx_r[30:0], 1'b0};
                if (bit_r < 6'd7) begin
                  state_r <= CMD;
                end else if (bit_r < 6'd31) begin
                  state_r <= ADDR;
                end else begin
                  state_r <= DATA;
                end
              end
            end
          end
        end
        RESP: begin
          state_r <= CSGAP;
          div_r   <= {DIV_W{1'b0}};
          phase_r <= 1'b0;
        end
        CSGAP: begin
          // Two SCK half-periods of deselect time before the next frame.
          if (div_r != DIV_LAST) begin
            div_r <= div_r + DIV_W'(1);
          end else begin
            div_r <= {DIV_W{1'b0}};
            if (phase_r) begin
              phase_r <= 1'b0;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else begin
              phase_r <= 1'b1;
            end
          end
        end
`ifdef SPI_FLASH_SEQ_READ_EN
        HOLD: begin
          if (req_i) begin
            if (seq_hit_s) begin
              gnt_r       <= 1'b1;
              state_r     <= DATA;
              bit_r       <= 6'd32;
              div_r       <= {DIV_W{1'b0}};
              phase_r     <= 1'b0;
              mosi_r      <= 1'b0;
              last_addr_r <= flash_addr_s;
            end else begin
              // Close the burst; the request is served from IDLE after the gap.
              cs_n_r  <= 1'b1;
              state_r <= CSGAP;
              div_r   <= {DIV_W{1'b0}};
              phase_r <= 1'b0;
            end
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          cs_n_r  <= 1'b1;
          sck_r   <= 1'b0;
          mosi_r  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o      = gnt_r;
  assign rvalid_o   = rvalid_r;
  assign err_o      = err_r;
  assign busy_o     = busy_r;
  assign rdata_o    = rdata_r;
  assign spi_sck_o  = sck_r;
  assign spi_cs_no  = cs_n_r;
  assign spi_mosi_o = mosi_r;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Testbench for spi_flash_reader: a byte-array SPI flash model answers READ
// frames, and each bus response is checked against the expected word computed
// directly from the byte array. The checks cover the address-window and write
// rules, latency in clk_i cycles, SCK edge counts, reset mid-frame and the
// chip-select gap between back-to-back reads.
module tb_spi_flash_reader;

  localparam int          CLK_DIV = 2;
  localparam logic [31:0] BASE    = 32'h2000_0000;
`ifdef SPI_FLASH_SEQ_READ_EN
  localparam bit SEQ_MODE = 1'b1;
`else
  localparam bit SEQ_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i, req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        spi_miso_i = 1'b0;
  logic        gnt_o, rvalid_o, err_o, busy_o, spi_sck_o, spi_cs_no, spi_mosi_o;
  logic [31:0] rdata_o;

  always #5 clk = ~clk;

  spi_flash_reader #(.FLASH_BASE_ADDR(BASE), .FLASH_ADDR_WIDTH(24), .CLK_DIV(CLK_DIV)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .busy_o(busy_o), .spi_sck_o(spi_sck_o), .spi_cs_no(spi_cs_no),
    .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- SPI flash model (256 bytes, aliased across the window) ----------------
  logic [7:0]  mem [256];
  logic [31:0] fl_sh = 32'h0;
  int          fl_cnt = 0;

  // flash: shift in command and address on SCK rise; deselect restarts the frame
  always @(posedge spi_sck_o or posedge spi_cs_no) begin
    if (spi_cs_no) begin
      fl_cnt <= 0;
    end else begin
      if (fl_cnt < 32) fl_sh <= {fl_sh[30:0], spi_mosi_o};
      fl_cnt <= fl_cnt + 1;
    end
  end

  // flash: once command and address are in, drive the next data bit on SCK fall
  always @(negedge spi_sck_o) begin
    if (spi_cs_no === 1'b0 && fl_cnt >= 32)
      spi_miso_i <= mem[fl_sh[7:0] + 8'((fl_cnt - 32) / 8)][3'(7 - ((fl_cnt - 32) % 8))];
  end

  // ---------------- monitors ----------------
  int sck_rise = 0, cs_low_cyc = 0, rv_cnt = 0, overlap = 0;

  // count rising SCK edges
  always @(posedge spi_sck_o) sck_rise <= sck_rise + 1;

  // count chip-select-low cycles, response pulses and grant/response overlaps
  always @(negedge clk) begin
    if (spi_cs_no === 1'b0) cs_low_cyc <= cs_low_cyc + 1;
    if (rvalid_o === 1'b1) rv_cnt <= rv_cnt + 1;
    if (gnt_o === 1'b1 && rvalid_o === 1'b1) overlap <= overlap + 1;
  end

  // ---------------- reference model ----------------
  bit          hold_v = 1'b0;
  logic [31:0] hold_off = 32'h0;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] o;
    logic [7:0]  b;
    o = a - BASE;
    b = o[7:0] & 8'hFC;
    return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
  endfunction

  function automatic bit ref_illegal(input logic [31:0] a, input logic w);
    return w || ((a - BASE) >= 32'h0100_0000);
  endfunction

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (gnt_o === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("gnt_timeout", 32'(gnt_o), 32'd1);
  endtask

  task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic er);
    lat = -1; rd = 32'h0; er = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk); #1;
      if (rvalid_o === 1'b1) begin lat = k; rd = rdata_o; er = err_o; break; end
    end
    if (lat < 0) check_eq("rvalid_timeout", 32'(rvalid_o), 32'd1);
  endtask

  // One complete bus access checked against the reference model.
  task automatic access(input logic [31:0] a, input logic w, input string tag);
    bit ok, ill, burst;
    int lat, s0, c0, exp_lat;
    logic [31:0] rd, off;
    logic er;
    ill   = ref_illegal(a, w);
    off   = (a - BASE) & 32'hFFFF_FFFC;
    burst = SEQ_MODE && hold_v && !ill && (off == hold_off + 32'd4);
    req_i = 1'b1; addr_i = a; we_i = w; wdata_i = $urandom; be_i = 4'($urandom);
    wait_gnt(ok);
    req_i = 1'b0; we_i = 1'b0;
    if (!ok) return;
    s0 = sck_rise; c0 = cs_low_cyc;
    check_eq({tag, "_busy_at_gnt"}, 32'(busy_o), 32'd1);
    wait_rsp(lat, rd, er);
    exp_lat = ill ? 1 : (burst ? 64 * CLK_DIV : 128 * CLK_DIV);
    check_eq({tag, "_rdata"}, rd, ill ? 32'hDEAD_BEEF : ref_word(a));
    check_eq({tag, "_err"}, 32'(er), 32'(ill));
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_sck_edges"}, sck_rise - s0, ill ? 0 : (burst ? 32 : 64));
    check_eq({tag, "_cs_low_cycles"}, cs_low_cyc - c0, ill ? 0 : exp_lat);
    if (!ill && !burst) check_eq({tag, "_cmd_addr"}, fl_sh, {8'h03, off[23:0]});
    hold_v   = !ill;
    hold_off = off;
  endtask

  // watchdog: the run must never hang
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int lat, r0, hi, kind;
    logic [31:0] rd, a, prev_a;
    logic er;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
    mem[4] = 8'hB7; mem[5] = 8'h05; mem[6] = 8'h00; mem[7] = 8'h20;

    rst_i = 1'b1; req_i = 1'b0; addr_i = 32'h0; we_i = 1'b0; wdata_i = 32'h0; be_i = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_gnt", 32'(gnt_o), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid_o), 32'd0);
    check_eq("rst_err", 32'(err_o), 32'd0);
    check_eq("rst_rdata", rdata_o, 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_cs_n", 32'(spi_cs_no), 32'd1);
    check_eq("rst_sck", 32'(spi_sck_o), 32'd0);
    check_eq("rst_mosi", 32'(spi_mosi_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    // T1: first word of the flash
    access(BASE, 1'b0, "t1");
    check_eq("t1_word", rdata_o, 32'h0000_0013);
    check_eq("t1_cs_at_rsp", 32'(spi_cs_no), 32'(!SEQ_MODE));
    check_eq("t1_sck_at_rsp", 32'(spi_sck_o), 32'd0);

    // T2/T3: write and out-of-window read are rejected without SPI activity
    access(BASE, 1'b1, "t2");
    check_eq("t2_busy_at_rsp", 32'(busy_o), 32'd0);
    access(32'h2100_0000, 1'b0, "t3");
    check_eq("t3_cs_at_rsp", 32'(spi_cs_no), 32'd1);

    // window boundaries and ignored low address bits
    access(32'h20FF_FFFC, 1'b0, "top");
    access(32'h1FFF_FFFC, 1'b0, "below");
    access(32'h2000_0003, 1'b0, "unalign");

    // randomized mix of accesses
    prev_a = BASE;
    for (int n = 0; n < 10; n++) begin
      kind = $urandom_range(0, 8);
      case (kind)
        0, 1, 2, 3: a = BASE + ($urandom & 32'h00FF_FFFF);
        4:          a = prev_a + 32'd4;
        5:          a = BASE + ($urandom & 32'h00FF_FFFF);
        6:          a = BASE + 32'h0100_0000 + ($urandom & 32'h0000_FFFF);
        7:          a = $urandom;
        default:    a = BASE + 32'($urandom_range(0, 255));
      endcase
      access(a, (kind == 5) ? 1'b1 : 1'b0, $sformatf("rnd%0d", n));
      prev_a = a;
    end

    // T4: reset in the middle of a frame
    access(BASE, 1'b1, "t4_pre");
    req_i = 1'b1; addr_i = BASE + 32'd8; we_i = 1'b0;
    wait_gnt(ok);
    req_i = 1'b0;
    repeat (150) @(posedge clk);
    #1; rst_i = 1'b1;
    @(posedge clk); #1;
    check_eq("t4_cs_n", 32'(spi_cs_no), 32'd1);
    check_eq("t4_sck", 32'(spi_sck_o), 32'd0);
    check_eq("t4_busy", 32'(busy_o), 32'd0);
    rst_i = 1'b0; hold_v = 1'b0;
    r0 = rv_cnt;
    repeat (300) @(posedge clk);
    #1;
    check_eq("t4_no_rvalid", rv_cnt, r0);
    access(BASE + 32'd8, 1'b0, "t4_after");

    // T5/T6: back-to-back reads with the request held
    req_i = 1'b1; addr_i = BASE; we_i = 1'b0;
    wait_gnt(ok);
    addr_i = BASE + 32'd4;
    wait_rsp(lat, rd, er);
    check_eq("t5_first_rdata", rd, 32'h0000_0013);
    check_eq("t5_first_lat", lat, 128 * CLK_DIV);
    hi = spi_cs_no ? 1 : 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (gnt_o === 1'b1) begin ok = 1'b1; break; end
      if (spi_cs_no === 1'b1) hi++;
    end
    req_i = 1'b0;
    if (!ok) check_eq("t5_gnt2_timeout", 32'(gnt_o), 32'd1);
    check_eq("t5_cs_gap_ok", 32'(SEQ_MODE ? (hi == 0) : (hi >= 4)), 32'd1);
    wait_rsp(lat, rd, er);
    check_eq("t5_second_rdata", rd, 32'h2000_05B7);
    check_eq("t5_second_err", 32'(er), 32'd0);
    check_eq("t5_second_lat", lat, SEQ_MODE ? 64 * CLK_DIV : 128 * CLK_DIV);
    repeat (10) @(posedge clk);
    #1;
    check_eq("rdata_held", rdata_o, 32'h2000_05B7);
    check_eq("gnt_rvalid_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
